// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs MIPS R/I/J field bundles into words
// and streams them into instruction memory from a base address.
module instr_encoder_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = AW + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  acc_left_q, acc_left_d;
    logic [CNT_W-1:0]  wr_left_q, wr_left_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [OCC_W-1:0]  occ_q;

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              illegal;
    logic [31:0]       enc_word;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    assign fifo_full  = (occ_q == FULL_OCC);
    assign fifo_empty = (occ_q == '0);

    assign in_ready = (state_q == S_LOAD) && !fifo_full && (acc_left_q != '0);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_LOAD) && !fifo_empty;

    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    // Pack the offered fields according to the selected format
    always_comb begin
        enc_word = '0;
        illegal  = 1'b0;
        unique case (fmt)
            2'd0: enc_word = {opcode, rs, rt, rd, shamt, funct};
            2'd1: enc_word = {opcode, rs, rt, imm};
            2'd2: enc_word = {opcode, jaddr};
            2'd3: illegal  = 1'b1;
        endcase
    end

    // Load FSM next state, write pointer and remaining-word counters
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        acc_left_d = acc_left_q;
        wr_left_d  = wr_left_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (count != '0) begin
                        state_d    = S_LOAD;
                        ptr_d      = base_addr;
                        acc_left_d = count;
                        wr_left_d  = count;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (push) begin
                    acc_left_d = acc_left_q - CNT_W'(1);
                    if (illegal) begin
                        err_d = 1'b1;
                    end
                end
                if (pop) begin
                    ptr_d     = ptr_q + ADDR_W'(4);
                    wr_left_d = wr_left_q - CNT_W'(1);
                    if (wr_left_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            acc_left_q <= '0;
            wr_left_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            acc_left_q <= acc_left_d;
            wr_left_q  <= wr_left_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while occupancy is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= enc_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Registered memory write port; address/data hold between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                addr_q  <= ptr_q;
                wdata_q <= mem_q[rptr_q];
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: random field bundles
// checked against an arithmetic encoding/address model.
module tb_instr_encoder_loader;

    typedef struct {
        int unsigned fmt;
        int unsigned op;
        int unsigned rs;
        int unsigned rt;
        int unsigned rd;
        int unsigned sh;
        int unsigned fn;
        int unsigned imm;
        int unsigned ja;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;

    int compared = 0;
    int mismatched = 0;

    int cyc = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          ac_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_cnt = 0;

    bundle_t     bq[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    int mark_w, mark_acc, mark_done, mark_ready;
    int start_cyc;
    bit post_ready, post_busy, tmo;

    instr_encoder_loader #(
        .FIFO_DEPTH(4),
        .ADDR_W(32),
        .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm(imm), .jaddr(jaddr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive log of writes, accepts, done pulses and ready cycles
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) ac_q.push_back(cyc);
        if (in_ready === 1'b1) ready_cnt = ready_cnt + 1;
    end

    function automatic logic [31:0] ref_word(input bundle_t b);
        longint unsigned v;
        case (b.fmt)
            0: v = b.op * 64'd67108864 + b.rs * 64'd2097152 + b.rt * 64'd65536
                 + b.rd * 64'd2048 + b.sh * 64'd64 + b.fn;
            1: v = b.op * 64'd67108864 + b.rs * 64'd2097152 + b.rt * 64'd65536
                 + b.imm;
            2: v = b.op * 64'd67108864 + b.ja;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bundle_t rand_bundle(input int unsigned f);
        bundle_t b;
        b.fmt = f;
        b.op  = $urandom_range(0, 63);
        b.rs  = $urandom_range(0, 31);
        b.rt  = $urandom_range(0, 31);
        b.rd  = $urandom_range(0, 31);
        b.sh  = $urandom_range(0, 31);
        b.fn  = $urandom_range(0, 63);
        b.imm = $urandom_range(0, 65535);
        b.ja  = $urandom & 32'h03FF_FFFF;
        return b;
    endfunction

    function automatic bundle_t mk(input int unsigned f, input int unsigned op,
                                   input int unsigned s, input int unsigned t,
                                   input int unsigned d, input int unsigned h,
                                   input int unsigned n, input int unsigned i,
                                   input int unsigned j);
        bundle_t b;
        b.fmt = f; b.op = op; b.rs = s; b.rt = t; b.rd = d;
        b.sh = h; b.fn = n; b.imm = i; b.ja = j;
        return b;
    endfunction

    // Expected write stream: word i goes to base + 4*i modulo 2^32
    task automatic build_expect(input logic [31:0] b, input int n);
        longint unsigned a;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < n; i++) begin
            a = (longint'(b) + 4 * i) % 64'h1_0000_0000;
            exp_a.push_back(a[31:0]);
            exp_d.push_back(ref_word(bq[i]));
        end
    endtask

    task automatic drive_fields(input bundle_t b);
        fmt    = 2'(b.fmt);
        opcode = 6'(b.op);
        rs     = 5'(b.rs);
        rt     = 5'(b.rt);
        rd     = 5'(b.rd);
        shamt  = 5'(b.sh);
        funct  = 6'(b.fn);
        imm    = 16'(b.imm);
        jaddr  = 26'(b.ja);
    endtask

    // Starts a load of n bundles from bq and waits (bounded) for done
    task automatic load_run(input logic [31:0] b, input int n, input bit allv);
        int  i;
        int  g;
        bit  acc;
        mark_w     = wa_q.size();
        mark_acc   = ac_q.size();
        mark_done  = done_cnt;
        mark_ready = ready_cnt;
        post_ready = 1'b0;
        post_busy  = 1'b0;
        base_addr  = b;
        count      = 8'(n);
        start      = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        i = 0;
        g = 0;
        while (i < n && g < 400) begin
            in_valid = allv ? 1'b1 : ($urandom_range(0, 2) != 0);
            drive_fields(bq[i]);
            @(negedge clk); #1;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        if (n > 0) begin
            @(negedge clk); #1;
            post_ready = in_ready;
            post_busy  = busy;
            @(posedge clk); #1;
        end
        while (done_cnt == mark_done && g < 600) begin
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tmo = (done_cnt == mark_done);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        compared++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {in_ready, imem_we, busy, done, err});
        end
        compared++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_bus got addr=%h data=%h exp 0/0",
                     imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int nw;
        bq.delete();
        bq.push_back(mk(0, 0, 1, 2, 3, 0, 32'h20, 0, 0));
        bq.push_back(mk(1, 32'h08, 1, 2, 0, 0, 0, 32'hFFFC, 0));
        bq.push_back(mk(2, 32'h02, 0, 0, 0, 0, 0, 0, 32'h10));
        load_run(32'h40, 3, 1'b1);
        compared++;
        if (tmo) begin
            mismatched++;
            $display("FAIL basic_timeout got=no_done exp=done");
        end
        nw = wa_q.size() - mark_w;
        compared++;
        if (nw !== 3) begin
            mismatched++;
            $display("FAIL basic_nwrites got=%0d exp=3", nw);
        end
        exp_a.delete();
        exp_d.delete();
        exp_a.push_back(32'h40); exp_d.push_back(32'h0022_1820);
        exp_a.push_back(32'h44); exp_d.push_back(32'h2022_FFFC);
        exp_a.push_back(32'h48); exp_d.push_back(32'h0800_0010);
        for (int i = 0; i < 3 && i < nw; i++) begin
            compared++;
            if (wa_q[mark_w+i] !== exp_a[i] || wd_q[mark_w+i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL basic_word%0d got %h@%h exp %h@%h", i,
                         wd_q[mark_w+i], wa_q[mark_w+i], exp_d[i], exp_a[i]);
            end
        end
        if (nw == 3) begin
            compared++;
            if (wc_q[mark_w] !== ac_q[mark_acc] + 2) begin
                mismatched++;
                $display("FAIL basic_latency got=%0d exp=%0d",
                         wc_q[mark_w], ac_q[mark_acc] + 2);
            end
            compared++;
            if (wc_q[mark_w+2] - wc_q[mark_w] !== 2) begin
                mismatched++;
                $display("FAIL basic_b2b got span=%0d exp=2",
                         wc_q[mark_w+2] - wc_q[mark_w]);
            end
            compared++;
            if (done_cyc !== wc_q[mark_w+2]) begin
                mismatched++;
                $display("FAIL basic_done_cyc got=%0d exp=%0d",
                         done_cyc, wc_q[mark_w+2]);
            end
        end
        compared++;
        if (ac_q[mark_acc] !== start_cyc) begin
            mismatched++;
            $display("FAIL basic_first_accept got=%0d exp=%0d",
                     ac_q[mark_acc], start_cyc);
        end
        compared++;
        if (done_cnt - mark_done !== 1 || err !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_end got done=%0d err=%b busy=%b exp 1/0/0",
                     done_cnt - mark_done, err, busy);
        end
    endtask

    task automatic test_count_zero;
        load_run(32'h100, 0, 1'b1);
        compared++;
        if (wa_q.size() - mark_w !== 0) begin
            mismatched++;
            $display("FAIL zero_writes got=%0d exp=0", wa_q.size() - mark_w);
        end
        compared++;
        if (done_cnt - mark_done !== 1 || done_cyc !== start_cyc) begin
            mismatched++;
            $display("FAIL zero_done got n=%0d cyc=%0d exp 1 at %0d",
                     done_cnt - mark_done, done_cyc, start_cyc);
        end
        compared++;
        if (ready_cnt - mark_ready !== 0) begin
            mismatched++;
            $display("FAIL zero_ready got=%0d exp=0", ready_cnt - mark_ready);
        end
    endtask

    task automatic test_burst;
        int nw;
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(rand_bundle($urandom_range(0, 2)));
        build_expect(32'h1000, 8);
        load_run(32'h1000, 8, 1'b1);
        compared++;
        if (ac_q.size() - mark_acc !== 8 || tmo) begin
            mismatched++;
            $display("FAIL burst_accepts got=%0d tmo=%b exp=8 tmo=0",
                     ac_q.size() - mark_acc, tmo);
        end
        compared++;
        if (post_ready !== 1'b0 || post_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL burst_ready_drop got rdy=%b busy=%b exp 0/1",
                     post_ready, post_busy);
        end
        nw = wa_q.size() - mark_w;
        compared++;
        if (nw !== 8) begin
            mismatched++;
            $display("FAIL burst_nwrites got=%0d exp=8", nw);
        end
        for (int i = 0; i < 8 && i < nw; i++) begin
            compared++;
            if (wa_q[mark_w+i] !== exp_a[i] || wd_q[mark_w+i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL burst_word%0d got %h@%h exp %h@%h", i,
                         wd_q[mark_w+i], wa_q[mark_w+i], exp_d[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_illegal;
        int nw;
        bq.delete();
        bq.push_back(rand_bundle(3));
        bq.push_back(rand_bundle(0));
        build_expect(32'h200, 2);
        load_run(32'h200, 2, 1'b0);
        nw = wa_q.size() - mark_w;
        compared++;
        if (nw !== 2 || tmo) begin
            mismatched++;
            $display("FAIL illegal_nwrites got=%0d tmo=%b exp=2", nw, tmo);
        end
        for (int i = 0; i < 2 && i < nw; i++) begin
            compared++;
            if (wa_q[mark_w+i] !== exp_a[i] || wd_q[mark_w+i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL illegal_word%0d got %h@%h exp %h@%h", i,
                         wd_q[mark_w+i], wa_q[mark_w+i], exp_d[i], exp_a[i]);
            end
        end
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_err_set got=%b exp=1", err);
        end
        load_run(32'h0, 0, 1'b0);
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_err_clear got=%b exp=0", err);
        end
    endtask

    task automatic test_wrap;
        int nw;
        bq.delete();
        bq.push_back(rand_bundle(1));
        bq.push_back(rand_bundle(2));
        build_expect(32'hFFFF_FFFC, 2);
        load_run(32'hFFFF_FFFC, 2, 1'b1);
        nw = wa_q.size() - mark_w;
        compared++;
        if (nw !== 2 || tmo) begin
            mismatched++;
            $display("FAIL wrap_nwrites got=%0d tmo=%b exp=2", nw, tmo);
        end
        for (int i = 0; i < 2 && i < nw; i++) begin
            compared++;
            if (wa_q[mark_w+i] !== exp_a[i] || wd_q[mark_w+i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL wrap_word%0d got %h@%h exp %h@%h", i,
                         wd_q[mark_w+i], wa_q[mark_w+i], exp_d[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_midload;
        int i;
        int g;
        bit acc;
        bq.delete();
        for (int k = 0; k < 5; k++) bq.push_back(rand_bundle($urandom_range(0, 2)));
        build_expect(32'h300, 5);
        mark_w    = wa_q.size();
        mark_done = done_cnt;
        base_addr = 32'h300;
        count     = 8'd5;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        g = 0;
        while (g < 100) begin
            in_valid = (i < 5);
            drive_fields(bq[i < 5 ? i : 4]);
            @(negedge clk); #1;
            if (wa_q.size() - mark_w >= 2) break;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        compared++;
        if (wa_q.size() - mark_w !== 2) begin
            mismatched++;
            $display("FAIL rst_mid_reach got=%0d exp=2", wa_q.size() - mark_w);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        compared++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs got ctl=%b a=%h d=%h exp 0",
                     {in_ready, imem_we, busy, done, err}, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        compared++;
        if (wa_q.size() - mark_w !== 2 || done_cnt - mark_done !== 0) begin
            mismatched++;
            $display("FAIL rst_mid_abort got w=%0d done=%0d exp 2/0",
                     wa_q.size() - mark_w, done_cnt - mark_done);
        end
        for (int k = 0; k < 2 && mark_w + k < wa_q.size(); k++) begin
            compared++;
            if (wa_q[mark_w+k] !== exp_a[k] || wd_q[mark_w+k] !== exp_d[k]) begin
                mismatched++;
                $display("FAIL rst_mid_word%0d got %h@%h exp %h@%h", k,
                         wd_q[mark_w+k], wa_q[mark_w+k], exp_d[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_random;
        int n;
        int nw;
        logic [31:0] b;
        bit exp_err;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            b = $urandom & 32'hFFFF_FFFC;
            bq.delete();
            exp_err = 1'b0;
            for (int k = 0; k < n; k++) begin
                bq.push_back(rand_bundle($urandom_range(0, 9) == 0 ? 3 :
                                         $urandom_range(0, 2)));
                if (bq[k].fmt == 3) exp_err = 1'b1;
            end
            build_expect(b, n);
            load_run(b, n, 1'b0);
            nw = wa_q.size() - mark_w;
            compared++;
            if (nw !== n || tmo || done_cnt - mark_done !== 1) begin
                mismatched++;
                $display("FAIL rand%0d_count got w=%0d done=%0d tmo=%b exp %0d/1",
                         r, nw, done_cnt - mark_done, tmo, n);
            end
            for (int k = 0; k < n && k < nw; k++) begin
                compared++;
                if (wa_q[mark_w+k] !== exp_a[k] || wd_q[mark_w+k] !== exp_d[k]) begin
                    mismatched++;
                    $display("FAIL rand%0d_word%0d got %h@%h exp %h@%h", r, k,
                             wd_q[mark_w+k], wa_q[mark_w+k], exp_d[k], exp_a[k]);
                end
            end
            compared++;
            if (err !== exp_err) begin
                mismatched++;
                $display("FAIL rand%0d_err got=%b exp=%b", r, err, exp_err);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        in_valid  = 1'b0;
        drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_basic();
        test_count_zero();
        test_burst();
        test_illegal();
        test_wrap();
        test_reset_midload();
        test_basic();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
